// File: rtl/tcu_multichan.sv
// N-channel timing control unit: one trigger edge launches a programmable pulse train per channel.
// Shadow configuration is copied to the active set at launch; out_cmp is the XOR of channels 0 and 1.
module tcu_multichan #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8,
    parameter int unsigned RW  = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    trig,
    input  logic                    cfg_we,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [CW-1:0]           cfg_delay,
    input  logic [CW-1:0]           cfg_width,
    input  logic [CW-1:0]           cfg_period,
    input  logic [RW-1:0]           cfg_repeat,
    input  logic                    err_clr,
    output logic [NCH-1:0]          out_pulse,
    output logic                    out_cmp,
    output logic                    busy,
    output logic                    done,
    output logic                    err_retrig
);

    localparam int unsigned CW1 = CW + 1;

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_e;

    logic            trig_d_q, trig_d_d;
    logic [CW-1:0]   sh_delay_q  [NCH], sh_delay_d  [NCH];
    logic [CW-1:0]   sh_width_q  [NCH], sh_width_d  [NCH];
    logic [CW-1:0]   sh_period_q [NCH], sh_period_d [NCH];
    logic [RW-1:0]   sh_repeat_q [NCH], sh_repeat_d [NCH];
    logic [CW-1:0]   act_width_q [NCH], act_width_d [NCH];
    logic [CW-1:0]   act_period_q[NCH], act_period_d[NCH];
    state_e          state_q     [NCH], state_d     [NCH];
    logic [CW-1:0]   cnt_q       [NCH], cnt_d       [NCH];
    logic [RW-1:0]   rep_q       [NCH], rep_d       [NCH];
    logic [NCH-1:0]  pulse_q, pulse_d;
    logic            cmp_q, cmp_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            trig_evt, launch, any_en, next_busy;

    // Low-gap length after a pulse: max(P, W+1) - W, minus one for the count-to-zero exit.
    function automatic logic [CW-1:0] gap_len(input logic [CW-1:0] w, input logic [CW-1:0] p);
        logic [CW:0] w1;
        logic [CW:0] peff;
        w1   = {1'b0, w} + CW1'(1);
        peff = ({1'b0, p} > w1) ? {1'b0, p} : w1;
        return CW'(peff - {1'b0, w} - CW1'(1));
    endfunction

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (state_q[i] != IDLE) busy = 1'b1;
        end
    end

    always_comb begin
        trig_d_d     = trig;
        sh_delay_d   = sh_delay_q;
        sh_width_d   = sh_width_q;
        sh_period_d  = sh_period_q;
        sh_repeat_d  = sh_repeat_q;
        act_width_d  = act_width_q;
        act_period_d = act_period_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        rep_d        = rep_q;
        pulse_d      = '0;
        any_en       = 1'b0;
        next_busy    = 1'b0;
        trig_evt     = trig & ~trig_d_q;
        launch       = trig_evt & ~busy;

        if (cfg_we && (32'(cfg_ch) < NCH)) begin
            sh_delay_d[cfg_ch]  = cfg_delay;
            sh_width_d[cfg_ch]  = cfg_width;
            sh_period_d[cfg_ch] = cfg_period;
            sh_repeat_d[cfg_ch] = cfg_repeat;
        end

        for (int i = 0; i < NCH; i++) begin
            if (launch) begin
                act_width_d[i]  = sh_width_q[i];
                act_period_d[i] = sh_period_q[i];
                if (sh_width_q[i] != '0) any_en = 1'b1;
            end
            case (state_q[i])
                IDLE: begin
                    if (launch && (sh_width_q[i] != '0)) begin
                        state_d[i] = DELAY;
                        cnt_d[i]   = sh_delay_q[i];
                        rep_d[i]   = sh_repeat_q[i];
                    end
                end
                DELAY, GAP: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = act_width_q[i] - CW'(1);
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CW'(1);
                    end
                end
                HIGH: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end else if (rep_q[i] == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        state_d[i] = GAP;
                        cnt_d[i]   = gap_len(act_width_q[i], act_period_q[i]);
                        rep_d[i]   = rep_q[i] - RW'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            pulse_d[i] = (state_d[i] == HIGH);
            if (state_d[i] != IDLE) next_busy = 1'b1;
        end

        cmp_d  = pulse_d[0] ^ pulse_d[1];
        // An all-disabled launch completes immediately.
        done_d = (launch & ~any_en) | (busy & ~next_busy);
        err_d  = (trig_evt & busy) | (err_q & ~err_clr);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            trig_d_q     <= 1'b0;
            sh_delay_q   <= '{default: '0};
            sh_width_q   <= '{default: '0};
            sh_period_q  <= '{default: '0};
            sh_repeat_q  <= '{default: '0};
            act_width_q  <= '{default: '0};
            act_period_q <= '{default: '0};
            state_q      <= '{default: IDLE};
            cnt_q        <= '{default: '0};
            rep_q        <= '{default: '0};
            pulse_q      <= '0;
            cmp_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            trig_d_q     <= trig_d_d;
            sh_delay_q   <= sh_delay_d;
            sh_width_q   <= sh_width_d;
            sh_period_q  <= sh_period_d;
            sh_repeat_q  <= sh_repeat_d;
            act_width_q  <= act_width_d;
            act_period_q <= act_period_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rep_q        <= rep_d;
            pulse_q      <= pulse_d;
            cmp_q        <= cmp_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign out_pulse  = pulse_q;
    assign out_cmp    = cmp_q;
    assign done       = done_q;
    assign err_retrig = err_q;

endmodule

// File: tb/tb_tcu_multichan.sv
// Directed bench for tcu_multichan: vector tables for simple frames, hand sequences for the corner cases.
module tb_tcu_multichan;

    logic        clk_in = 1'b0;
    logic        reset, trig, cfg_we, err_clr;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_delay, cfg_width, cfg_period;
    logic [3:0]  cfg_repeat;
    logic [3:0]  out_pulse;
    logic        out_cmp, busy, done, err_retrig;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       trig;
        logic [3:0] pulse;
        logic       cmp;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [19];

    tcu_multichan #(.NCH(4), .CW(8), .RW(4)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .trig       (trig),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_repeat (cfg_repeat),
        .err_clr    (err_clr),
        .out_pulse  (out_pulse),
        .out_cmp    (out_cmp),
        .busy       (busy),
        .done       (done),
        .err_retrig (err_retrig)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cfg(input int ch, input int d, input int w, input int p, input int r);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_delay  = 8'(d);
        cfg_width  = 8'(w);
        cfg_period = 8'(p);
        cfg_repeat = 4'(r);
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic trig_pulse;
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            trig = tbl[i].trig;
            tick();
            check($sformatf("vec%0d_pulse", i), 32'(out_pulse), 32'(tbl[i].pulse));
            check($sformatf("vec%0d_cmp", i),   32'(out_cmp),   32'(tbl[i].cmp));
            check($sformatf("vec%0d_busy", i),  32'(busy),      32'(tbl[i].busy));
            check($sformatf("vec%0d_done", i),  32'(done),      32'(tbl[i].done));
        end
        trig = 1'b0;
    endtask

    initial begin
        int hi_cnt;
        int done_at;
        logic e0, e1;

        // Single pulse on ch0 (D=0 W=2 R=0): rows are values just after edges k..k+4.
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        // Period clamp on ch2 (D=2 W=4 P=3 R=1): rises after k+3 and k+8.
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; trig = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
        cfg_ch = '0; cfg_delay = '0; cfg_width = '0; cfg_period = '0; cfg_repeat = '0;
        tick();
        check("rst_pulse", 32'(out_pulse), 32'h0);
        check("rst_cmp",   32'(out_cmp),   32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_done",  32'(done),      32'h0);
        check("rst_err",   32'(err_retrig), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        cfg(0, 0, 2, 0, 0);
        run_vecs(0, 4);

        cfg(0, 0, 0, 0, 0);
        cfg(2, 2, 4, 3, 1);
        run_vecs(5, 18);

        // Doubler: ch0 D=0, ch1 D=1, both W=2 P=5 R=3.
        cfg(2, 0, 0, 0, 0);
        cfg(0, 0, 2, 5, 3);
        cfg(1, 1, 2, 5, 3);
        trig_pulse();
        check("dbl_busy0", 32'(busy), 32'h1);
        for (int j = 1; j <= 20; j++) begin
            tick();
            e0 = (j <= 17) && (((j - 1) % 5) < 2);
            e1 = (j >= 2) && (j <= 18) && (((j - 2) % 5) < 2);
            check($sformatf("dbl_p0_%0d", j), 32'(out_pulse[0]), 32'(e0));
            check($sformatf("dbl_p1_%0d", j), 32'(out_pulse[1]), 32'(e1));
            check($sformatf("dbl_cmp_%0d", j), 32'(out_cmp), 32'(e0 ^ e1));
            check($sformatf("dbl_done_%0d", j), 32'(done), 32'(j == 19));
            check($sformatf("dbl_busy_%0d", j), 32'(busy), 32'(j <= 18));
        end

        // Retrigger while busy plus a shadow write that must not disturb the running frame.
        cfg(1, 0, 0, 0, 0);
        trig_pulse();
        cfg(0, 0, 7, 0, 0);
        trig_pulse();
        check("retrig_err_set", 32'(err_retrig), 32'h1);
        for (int j = 3; j <= 20; j++) begin
            tick();
            e0 = (j <= 17) && (((j - 1) % 5) < 2);
            check($sformatf("retrig_p0_%0d", j), 32'(out_pulse[0]), 32'(e0));
            check($sformatf("retrig_done_%0d", j), 32'(done), 32'(j == 18));
        end
        check("retrig_err_hold", 32'(err_retrig), 32'h1);
        trig_pulse();
        check("w7_busy", 32'(busy), 32'h1);
        tick();
        check("w7_rise", 32'(out_pulse[0]), 32'h1);
        trig = 1'b1; err_clr = 1'b1;
        tick();
        trig = 1'b0; err_clr = 1'b0;
        check("err_set_wins", 32'(err_retrig), 32'h1);
        hi_cnt  = 2;
        done_at = 0;
        for (int j = 3; j <= 10; j++) begin
            tick();
            if (out_pulse[0]) hi_cnt++;
            if (done && done_at == 0) done_at = j;
        end
        check("w7_width", 32'(hi_cnt), 32'd7);
        check("w7_done_at", 32'(done_at), 32'd8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err_retrig), 32'h0);

        // Write and trigger on the same edge: this frame keeps D=1, the next one sees D=5.
        cfg(0, 0, 0, 0, 0);
        cfg(1, 1, 1, 0, 0);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_delay = 8'd5; cfg_width = 8'd1;
        cfg_period = 8'd0; cfg_repeat = 4'd0;
        trig_pulse();
        cfg_we = 1'b0;
        tick();
        check("coll_k1", 32'(out_pulse), 32'h0);
        tick();
        check("coll_k2", 32'(out_pulse), 32'h2);
        tick();
        check("coll_k3_pulse", 32'(out_pulse), 32'h0);
        check("coll_k3_done",  32'(done), 32'h1);
        tick();
        trig_pulse();
        for (int j = 1; j <= 7; j++) begin
            tick();
            check($sformatf("coll_next_%0d", j), 32'(out_pulse[1]), 32'(j == 6));
        end

        // Reset during HIGH aborts the frame with no done.
        cfg(1, 0, 4, 0, 0);
        trig_pulse();
        tick();
        tick();
        check("rmid_high", 32'(out_pulse), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_pulse", 32'(out_pulse), 32'h0);
        check("rmid_cmp",   32'(out_cmp), 32'h0);
        check("rmid_busy",  32'(busy), 32'h0);
        check("rmid_done",  32'(done), 32'h0);
        tick();
        tick();
        check("rmid_nodone", 32'(done), 32'h0);
        trig_pulse();
        check("rmid_trig_busy", 32'(busy), 32'h0);
        check("rmid_trig_done", 32'(done), 32'h1);
        check("rmid_trig_pulse", 32'(out_pulse), 32'h0);
        tick();
        check("rmid_after_pulse", 32'(out_pulse), 32'h0);
        check("rmid_after_done",  32'(done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
